alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters, e.g. the execute stage and the address/branch-compare unit.
- Each requester issues an operation with a valid/ready handshake and receives the registered result through a valid/ready response channel.
- Round-robin arbitration; one operation in flight at a time.
- Drives the ALU operand/op inputs from internal registers and captures its outputs.

---
 rtl/alu_arbiter.sv | 175 +++++++++++++++++
 tb/tb_alu_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between NUM_REQ requesters.
//   Round-robin grant in IDLE, operands registered, ALU result captured one cycle
//   later and returned on a per-requester valid/ready response channel.
// Latency: request accepted in cycle N, response valid from cycle N+2; 3 cycles min per op.
// Backpressure: a stalled response holds result/flags stable and blocks all new grants.
// Ports:
//   i_Clock, i_Reset_n            clock (rising edge), async active-low reset
//   i_ReqValid/o_ReqReady         per-requester request handshake
//   i_ReqAluOp/AluOpAlt/Source1/2 per-requester payload, packed by requester index
//   o_RspValid/i_RspReady         per-requester response handshake
//   o_RspResult/Zero/LessThan/LessThanUnsigned  registered ALU outputs
//   o_Alu*                        drive the external ALU from the operand registers
//   i_Alu*                        external ALU result and flags
module alu_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic [NUM_REQ-1:0]     i_ReqValid,
  output logic [NUM_REQ-1:0]     o_ReqReady,
  input  logic [3*NUM_REQ-1:0]   i_ReqAluOp,
  input  logic [NUM_REQ-1:0]     i_ReqAluOpAlt,
  input  logic [32*NUM_REQ-1:0]  i_ReqSource1,
  input  logic [32*NUM_REQ-1:0]  i_ReqSource2,
  output logic [NUM_REQ-1:0]     o_RspValid,
  input  logic [NUM_REQ-1:0]     i_RspReady,
  output logic [31:0]            o_RspResult,
  output logic                   o_RspZero,
  output logic                   o_RspLessThan,
  output logic                   o_RspLessThanUnsigned,
  output logic [2:0]             o_AluOp,
  output logic                   o_AluOpAlt,
  output logic [31:0]            o_AluSource1,
  output logic [31:0]            o_AluSource2,
  input  logic [31:0]            i_AluOutput,
  input  logic                   i_AluZero,
  input  logic                   i_AluLessThan,
  input  logic                   i_AluLessThanUnsigned
);

  localparam int IW = (NUM_REQ > 2) ? 2 : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] grant_idx;

  logic [2:0]    op_q;
  logic          alt_q;
  logic [31:0]   src1_q;
  logic [31:0]   src2_q;

  logic [31:0]   result_q;
  logic          zero_q;
  logic          lt_q;
  logic          ltu_q;

  // Round-robin search: first valid requester at or after ptr, wrapping.
  // Constant indices only, so the loops unroll into a plain priority mux.
  logic          found;
  logic [IW-1:0] pick;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!found && i_ReqValid[k] && (((int'(ptr) + i) % NUM_REQ) == k)) begin
          found = 1'b1;
          pick  = IW'(k);
        end
      end
    end
  end

  logic [IW-1:0] next_ptr;
  assign next_ptr = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;

  // Payload of the winning requester.
  logic [2:0]  op_n;
  logic        alt_n;
  logic [31:0] src1_n;
  logic [31:0] src2_n;
  always_comb begin
    op_n   = '0;
    alt_n  = 1'b0;
    src1_n = '0;
    src2_n = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick == IW'(k)) begin
        op_n   = i_ReqAluOp[3*k +: 3];
        alt_n  = i_ReqAluOpAlt[k];
        src1_n = i_ReqSource1[32*k +: 32];
        src2_n = i_ReqSource2[32*k +: 32];
      end
    end
  end

  // Only the granted requester's ready can complete the response.
  logic rsp_hs;
  always_comb begin
    rsp_hs = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == IW'(k)) rsp_hs = i_RspReady[k];
    end
  end

  logic grant_now;
  // Gated by reset so no request appears accepted while reset is held.
  assign grant_now = i_Reset_n && (state == ST_IDLE) && found;

  always_comb begin
    o_ReqReady = '0;
    o_RspValid = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      o_ReqReady[k] = grant_now && (pick == IW'(k));
      o_RspValid[k] = (state == ST_RESP) && (grant_idx == IW'(k));
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      grant_idx <= '0;
      op_q      <= '0;
      alt_q     <= 1'b0;
      src1_q    <= '0;
      src2_q    <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      lt_q      <= 1'b0;
      ltu_q     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            op_q      <= op_n;
            alt_q     <= alt_n;
            src1_q    <= src1_n;
            src2_q    <= src2_n;
            grant_idx <= pick;
            ptr       <= next_ptr;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= i_AluOutput;
          zero_q   <= i_AluZero;
          lt_q     <= i_AluLessThan;
          ltu_q    <= i_AluLessThanUnsigned;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ALU inputs come straight from the operand registers and hold after completion.
  assign o_AluOp      = op_q;
  assign o_AluOpAlt   = alt_q;
  assign o_AluSource1 = src1_q;
  assign o_AluSource2 = src2_q;

  assign o_RspResult           = result_q;
  assign o_RspZero             = zero_q;
  assign o_RspLessThan         = lt_q;
  assign o_RspLessThanUnsigned = ltu_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  localparam int NUM_REQ = 2;

  logic                  i_Clock;
  logic                  i_Reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    o_ReqReady;
  logic [3*NUM_REQ-1:0]  req_op;
  logic [NUM_REQ-1:0]    req_alt;
  logic [32*NUM_REQ-1:0] req_s1;
  logic [32*NUM_REQ-1:0] req_s2;
  logic [NUM_REQ-1:0]    o_RspValid;
  logic [NUM_REQ-1:0]    rsp_ready;
  logic [31:0]           o_RspResult;
  logic                  o_RspZero;
  logic                  o_RspLessThan;
  logic                  o_RspLessThanUnsigned;
  logic [2:0]            o_AluOp;
  logic                  o_AluOpAlt;
  logic [31:0]           o_AluSource1;
  logic [31:0]           o_AluSource2;
  logic [31:0]           alu_out;
  logic                  alu_zero;
  logic                  alu_lt;
  logic                  alu_ltu;

  alu_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .i_Clock               (i_Clock),
    .i_Reset_n             (i_Reset_n),
    .i_ReqValid            (req_valid),
    .o_ReqReady            (o_ReqReady),
    .i_ReqAluOp            (req_op),
    .i_ReqAluOpAlt         (req_alt),
    .i_ReqSource1          (req_s1),
    .i_ReqSource2          (req_s2),
    .o_RspValid            (o_RspValid),
    .i_RspReady            (rsp_ready),
    .o_RspResult           (o_RspResult),
    .o_RspZero             (o_RspZero),
    .o_RspLessThan         (o_RspLessThan),
    .o_RspLessThanUnsigned (o_RspLessThanUnsigned),
    .o_AluOp               (o_AluOp),
    .o_AluOpAlt            (o_AluOpAlt),
    .o_AluSource1          (o_AluSource1),
    .o_AluSource2          (o_AluSource2),
    .i_AluOutput           (alu_out),
    .i_AluZero             (alu_zero),
    .i_AluLessThan         (alu_lt),
    .i_AluLessThanUnsigned (alu_ltu)
  );

  initial i_Clock = 1'b0;
  always #5 i_Clock = ~i_Clock;

  // External ALU: RISC-V funct3 encoding, flags compare the two sources.
  always_comb begin
    case (o_AluOp)
      3'd0:    alu_out = o_AluOpAlt ? (o_AluSource1 - o_AluSource2) : (o_AluSource1 + o_AluSource2);
      3'd1:    alu_out = o_AluSource1 << o_AluSource2[4:0];
      3'd2:    alu_out = {31'd0, $signed(o_AluSource1) < $signed(o_AluSource2)};
      3'd3:    alu_out = {31'd0, o_AluSource1 < o_AluSource2};
      3'd4:    alu_out = o_AluSource1 ^ o_AluSource2;
      3'd5:    alu_out = o_AluOpAlt ? 32'($signed(o_AluSource1) >>> o_AluSource2[4:0])
                                    : (o_AluSource1 >> o_AluSource2[4:0]);
      3'd6:    alu_out = o_AluSource1 | o_AluSource2;
      default: alu_out = o_AluSource1 & o_AluSource2;
    endcase
    alu_zero = (alu_out == 32'd0);
    alu_lt   = $signed(o_AluSource1) < $signed(o_AluSource2);
    alu_ltu  = o_AluSource1 < o_AluSource2;
  end

  typedef struct {
    logic [2:0]  op;
    logic        alt;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] res;
    logic        zero;
    logic        lt;
    logic        ltu;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] onehot(input int k);
    logic [NUM_REQ-1:0] r;
    r    = '0;
    r[k] = 1'b1;
    return r;
  endfunction

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic set_req(input int k, input logic [2:0] op, input logic alt,
                         input logic [31:0] s1, input logic [31:0] s2);
    req_valid[k]       = 1'b1;
    req_op[3*k +: 3]   = op;
    req_alt[k]         = alt;
    req_s1[32*k +: 32] = s1;
    req_s2[32*k +: 32] = s2;
  endtask

  task automatic clr_req(input int k);
    req_valid[k] = 1'b0;
  endtask

  task automatic apply_reset();
    i_Reset_n = 1'b0;
    tick();
    i_Reset_n = 1'b1;
  endtask

  int grants0, grants1, rsps0, rsps1;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    //              op    alt   s1            s2            res           z     lt    ltu
    vecs[0] = '{3'd0, 1'b0, 32'd5,        32'd7,        32'd12,       1'b0, 1'b1, 1'b1};
    vecs[1] = '{3'd0, 1'b1, 32'd3,        32'd3,        32'd0,        1'b1, 1'b0, 1'b0};
    vecs[2] = '{3'd3, 1'b0, 32'd1,        32'd2,        32'd1,        1'b0, 1'b1, 1'b1};
    vecs[3] = '{3'd2, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b1, 1'b0};
    vecs[4] = '{3'd4, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b1, 1'b1};
    vecs[5] = '{3'd5, 1'b1, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{3'd5, 1'b0, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'd1, 1'b0, 32'd1,        32'd31,       32'h80000000, 1'b0, 1'b1, 1'b1};
    vecs[8] = '{3'd6, 1'b0, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{3'd7, 1'b0, 32'h00001234, 32'd0,        32'd0,        1'b1, 1'b0, 1'b0};

    i_Reset_n = 1'b0;
    req_valid = '0;
    req_op    = '0;
    req_alt   = '0;
    req_s1    = '0;
    req_s2    = '0;
    rsp_ready = '1;

    // Reset state
    #3;
    chk("rst req_ready", 32'(o_ReqReady), 32'd0);
    chk("rst rsp_valid", 32'(o_RspValid), 32'd0);
    chk("rst result", o_RspResult, 32'd0);
    chk("rst flags", {29'd0, o_RspZero, o_RspLessThan, o_RspLessThanUnsigned}, 32'd0);
    chk("rst alu_op", {28'd0, o_AluOp, o_AluOpAlt}, 32'd0);
    chk("rst alu_src1", o_AluSource1, 32'd0);
    chk("rst alu_src2", o_AluSource2, 32'd0);
    tick();
    i_Reset_n = 1'b1;

    // Simultaneous requests from reset: req0 wins, then req1
    set_req(0, 3'd0, 1'b1, 32'd3, 32'd3);
    set_req(1, 3'd3, 1'b0, 32'd1, 32'd2);
    #2;
    chk("sim grant0", 32'(o_ReqReady), 32'(onehot(0)));
    tick();
    clr_req(0);
    #2;
    chk("sim exec ready", 32'(o_ReqReady), 32'd0);
    tick();
    #2;
    chk("sim rsp0 valid", 32'(o_RspValid), 32'(onehot(0)));
    chk("sim rsp0 result", o_RspResult, 32'd0);
    chk("sim rsp0 zero", 32'(o_RspZero), 32'd1);
    tick();
    #2;
    chk("sim grant1", 32'(o_ReqReady), 32'(onehot(1)));
    tick();
    clr_req(1);
    tick();
    #2;
    chk("sim rsp1 valid", 32'(o_RspValid), 32'(onehot(1)));
    chk("sim rsp1 result", o_RspResult, 32'd1);
    chk("sim rsp1 ltu", 32'(o_RspLessThanUnsigned), 32'd1);
    tick();

    // Table-driven single ops, alternating requester
    for (int i = 0; i < NV; i++) begin
      int k;
      k = i % NUM_REQ;
      set_req(k, vecs[i].op, vecs[i].alt, vecs[i].s1, vecs[i].s2);
      #2;
      chk("vec req_ready", 32'(o_ReqReady), 32'(onehot(k)));
      chk("vec idle rsp_valid", 32'(o_RspValid), 32'd0);
      tick();
      clr_req(k);
      #2;
      chk("vec exec ready", 32'(o_ReqReady), 32'd0);
      chk("vec alu_src1", o_AluSource1, vecs[i].s1);
      chk("vec alu_src2", o_AluSource2, vecs[i].s2);
      tick();
      #2;
      chk("vec rsp_valid", 32'(o_RspValid), 32'(onehot(k)));
      chk("vec result", o_RspResult, vecs[i].res);
      chk("vec zero", 32'(o_RspZero), 32'(vecs[i].zero));
      chk("vec lt", 32'(o_RspLessThan), 32'(vecs[i].lt));
      chk("vec ltu", 32'(o_RspLessThanUnsigned), 32'(vecs[i].ltu));
      tick();
      #2;
      chk("vec back idle", 32'(o_RspValid), 32'd0);
    end

    // Fairness: both requesters held valid
    apply_reset();
    set_req(0, 3'd0, 1'b0, 32'd10, 32'd1);
    set_req(1, 3'd0, 1'b0, 32'd20, 32'd2);
    for (int n = 0; n < 6; n++) begin
      #2;
      chk("fair grant", 32'(o_ReqReady), 32'(onehot(n % 2)));
      tick();
      tick();
      #2;
      chk("fair rsp_valid", 32'(o_RspValid), 32'(onehot(n % 2)));
      chk("fair result", o_RspResult, (n % 2 == 0) ? 32'd11 : 32'd22);
      tick();
    end
    clr_req(0);
    clr_req(1);

    // Stalled response blocks new grants; non-granted ready is ignored
    set_req(0, 3'd2, 1'b0, 32'hFFFFFFFF, 32'd1);
    set_req(1, 3'd0, 1'b0, 32'd1, 32'd1);
    rsp_ready = 2'b10;
    #2;
    chk("stall grant0", 32'(o_ReqReady), 32'(onehot(0)));
    tick();
    clr_req(0);
    tick();
    for (int n = 0; n < 5; n++) begin
      #2;
      chk("stall rsp_valid", 32'(o_RspValid), 32'(onehot(0)));
      chk("stall result", o_RspResult, 32'd1);
      chk("stall no grant", 32'(o_ReqReady), 32'd0);
      tick();
    end
    rsp_ready = '1;
    #2;
    chk("stall release valid", 32'(o_RspValid), 32'(onehot(0)));
    tick();
    #2;
    chk("stall next grant1", 32'(o_ReqReady), 32'(onehot(1)));
    tick();
    clr_req(1);
    tick();
    #2;
    chk("stall rsp1 result", o_RspResult, 32'd2);
    tick();

    // Reset asserted mid-EXEC
    set_req(0, 3'd0, 1'b0, 32'd5, 32'd7);
    #2;
    chk("rexec grant", 32'(o_ReqReady), 32'(onehot(0)));
    tick();
    #2;
    i_Reset_n = 1'b0;
    #1;
    chk("rexec req_ready", 32'(o_ReqReady), 32'd0);
    chk("rexec rsp_valid", 32'(o_RspValid), 32'd0);
    chk("rexec alu_src1", o_AluSource1, 32'd0);
    chk("rexec result", o_RspResult, 32'd0);
    tick();
    i_Reset_n = 1'b1;
    grants0 = 0;
    rsps0   = 0;
    for (int n = 0; n < 6; n++) begin
      #2;
      if (o_ReqReady[0]) grants0++;
      if (o_RspValid[0]) begin
        rsps0++;
        chk("rexec rsp result", o_RspResult, 32'd12);
      end
      tick();
      if (grants0 > 0) clr_req(0);
    end
    chk("rexec grants", 32'(grants0), 32'd1);
    chk("rexec responses", 32'(rsps0), 32'd1);

    // req1 withdraws before being granted
    apply_reset();
    set_req(0, 3'd6, 1'b0, 32'd1, 32'd2);
    set_req(1, 3'd0, 1'b0, 32'd9, 32'd9);
    #2;
    chk("wd grant0", 32'(o_ReqReady), 32'(onehot(0)));
    tick();
    clr_req(0);
    clr_req(1);
    grants1 = 0;
    rsps1   = 0;
    rsps0   = 0;
    for (int n = 0; n < 8; n++) begin
      #2;
      if (o_ReqReady[1]) grants1++;
      if (o_RspValid[1]) rsps1++;
      if (o_RspValid[0]) begin
        rsps0++;
        chk("wd rsp0 result", o_RspResult, 32'd3);
      end
      tick();
    end
    chk("wd req1 grants", 32'(grants1), 32'd0);
    chk("wd req1 responses", 32'(rsps1), 32'd0);
    chk("wd req0 responses", 32'(rsps0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
